onc_16_dmem: RTL and testbench

Data-memory responder for the ONC-16 CPU data port: answers `dmem_addr`/`dmem_dout`/`dmem_we` with `dmem_din`. It holds a word-addressed RAM and a memory-mapped 8N1 UART transmitter with a small TX FIFO. Programs such as the hello-world ROM can therefore print characters. It sits beside the CPU core at top level, opposite the CPU's data-memory initiator port.

---
 rtl/onc_16_dmem_pkg.sv | 42 ++++
 rtl/onc_16_uart_tx.sv | 115 +++++++++++
 rtl/onc_16_dmem.sv | 120 ++++++++++++
 tb/tb_onc_16_dmem.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onc_16_dmem_pkg.sv
// Shared constants, types and helpers for the ONC-16 data-memory responder.
// Word width, undefined-read value, UART register addresses and STAT bit layout.
package onc_16_dmem_pkg;

    localparam int DATA_W = 16;
    localparam logic [15:0] DATA_UD = 16'hDEAD;

    localparam logic [15:0] DMEM_UART_DATA_ADDR = 16'hFF00;
    localparam logic [15:0] DMEM_UART_STAT_ADDR = 16'hFF01;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_CNT_LSB   = 4;
    localparam int STAT_CNT_MSB   = 7;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [DATA_W-1:0] pack_stat(
        input logic       busy,
        input logic       full,
        input logic       empty,
        input logic       ovf,
        input logic [3:0] count
    );
        logic [DATA_W-1:0] stat;
        stat = {DATA_W{1'b0}};
        stat[STAT_BUSY_BIT]               = busy;
        stat[STAT_FULL_BIT]               = full;
        stat[STAT_EMPTY_BIT]              = empty;
        stat[STAT_OVF_BIT]                = ovf;
        stat[STAT_CNT_MSB:STAT_CNT_LSB]   = count;
        return stat;
    endfunction

endpackage

// File: rtl/onc_16_uart_tx.sv
// 8N1 UART transmitter: pops one byte per frame through a valid/ready handshake.
// Ready is offered while idle and on the last stop-bit cycle, so queued bytes chain gap-free.
module onc_16_uart_tx
    import onc_16_dmem_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       n_rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       txd
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [2:0]       bit_idx_r, bit_idx_nxt_s;
    logic [7:0]       shift_r, shift_nxt_s;
    logic             txd_r, txd_nxt_s;
    logic             bit_last_s;

    assign bit_last_s = (cnt_r == CNT_LAST);
    assign tx_ready   = (state_r == TX_IDLE) || ((state_r == TX_STOP) && bit_last_s);
    assign tx_busy    = (state_r != TX_IDLE);
    assign txd        = txd_r;

    // Next-state, counter, shifter and line-level logic.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        txd_nxt_s     = txd_r;
        case (state_r)
            TX_IDLE: begin
                txd_nxt_s = 1'b1;
                if (tx_valid) begin
                    state_nxt_s = TX_START;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    shift_nxt_s = tx_data;
                    txd_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (bit_last_s) begin
                    state_nxt_s   = TX_DATA;
                    cnt_nxt_s     = {CNT_W{1'b0}};
                    bit_idx_nxt_s = 3'd0;
                    txd_nxt_s     = shift_r[0];
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (bit_last_s) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = TX_STOP;
                        txd_nxt_s   = 1'b1;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                        shift_nxt_s   = {1'b0, shift_r[7:1]};
                        txd_nxt_s     = shift_r[1];
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (bit_last_s) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                    if (tx_valid) begin
                        state_nxt_s = TX_START;
                        shift_nxt_s = tx_data;
                        txd_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = TX_IDLE;
                        txd_nxt_s   = 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = TX_IDLE;
                txd_nxt_s   = 1'b1;
            end
        endcase
    end

    // Transmitter state registers; reset forces the line high at once.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_r   <= TX_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            txd_r     <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            txd_r     <= txd_nxt_s;
        end
    end

endmodule

// File: rtl/onc_16_dmem.sv
// ONC-16 data-memory responder: word RAM, UART DATA/STAT registers and the TX FIFO.
// Define ONC_16_DMEM_OVF_EN to add the sticky STAT overflow flag (cleared by a STAT write).
module onc_16_dmem
    import onc_16_dmem_pkg::*;
#(
    parameter int RAM_AW       = 10,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_dout,
    input  logic              dmem_we,
    output logic [DATA_W-1:0] dmem_din,
    output logic              txd
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] ram_r [0:(2**RAM_AW)-1];
    logic [7:0]        fifo_r [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic ram_sel_s, data_sel_s, stat_sel_s;
    logic push_req_s, push_ok_s, pop_s, full_s, empty_s;
    logic tx_ready_s, tx_busy_s, ovf_s;

    assign ram_sel_s  = (dmem_addr[DATA_W-1:RAM_AW] == {(DATA_W-RAM_AW){1'b0}});
    assign data_sel_s = (dmem_addr == DMEM_UART_DATA_ADDR);
    assign stat_sel_s = (dmem_addr == DMEM_UART_STAT_ADDR);

    assign full_s     = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign pop_s      = tx_ready_s & ~empty_s;
    assign push_req_s = dmem_we & data_sel_s;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push_ok_s  = push_req_s & (~full_s | pop_s);

    // RAM write port; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (dmem_we && ram_sel_s) begin
            ram_r[dmem_addr[RAM_AW-1:0]] <= dmem_dout;
        end
    end

    // FIFO byte storage; only the upper data byte of a DATA write is discarded.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            fifo_r[wr_ptr_r] <= dmem_dout[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_s);
        end
    end

`ifdef ONC_16_DMEM_OVF_EN
    logic ovf_r;

    // Sticky overflow flag; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            ovf_r <= 1'b0;
        end else if (push_req_s && !push_ok_s) begin
            ovf_r <= 1'b1;
        end else if (dmem_we && stat_sel_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf_s = ovf_r;
`else
    assign ovf_s = 1'b0;
`endif

    // Combinational read mux following the address map.
    always_comb begin
        dmem_din = DATA_UD;
        if (ram_sel_s) begin
            dmem_din = ram_r[dmem_addr[RAM_AW-1:0]];
        end else if (data_sel_s) begin
            dmem_din = 16'h0000;
        end else if (stat_sel_s) begin
            dmem_din = pack_stat(tx_busy_s, full_s, empty_s, ovf_s, 4'(count_r));
        end else begin
            dmem_din = DATA_UD;
        end
    end

    onc_16_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clock   (clock),
        .n_rst   (n_rst),
        .tx_valid(~empty_s),
        .tx_data (fifo_r[rd_ptr_r]),
        .tx_ready(tx_ready_s),
        .tx_busy (tx_busy_s),
        .txd     (txd)
    );

endmodule

// File: tb/tb_onc_16_dmem.sv
// Self-checking bench for onc_16_dmem: vector table, UART frame sequences and a random RAM model.
module tb_onc_16_dmem;

    localparam int RAM_AW = 8;
    localparam int CPB    = 4;
    localparam logic [15:0] UD    = 16'hDEAD;
    localparam logic [15:0] UDATA = 16'hFF00;
    localparam logic [15:0] USTAT = 16'hFF01;
`ifdef ONC_16_DMEM_OVF_EN
    localparam logic [15:0] OVF_BIT = 16'h0008;
`else
    localparam logic [15:0] OVF_BIT = 16'h0000;
`endif

    logic        clock = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] dmem_addr = 16'h0000;
    logic [15:0] dmem_dout = 16'h0000;
    logic        dmem_we = 1'b0;
    logic [15:0] dmem_din;
    logic        txd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    onc_16_dmem #(
        .RAM_AW(RAM_AW),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(4)
    ) dut (
        .clock    (clock),
        .n_rst    (n_rst),
        .dmem_addr(dmem_addr),
        .dmem_dout(dmem_dout),
        .dmem_we  (dmem_we),
        .dmem_din (dmem_din),
        .txd      (txd)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Serial receiver: decodes every frame seen on txd, sampling mid-bit.
    logic [7:0] rx_b;
    int         rx_f;
    bit         rx_ok;
    logic [7:0] rx_q[$];
    int         fall_q[$];
    bit         ok_q[$];
    always begin
        @(negedge txd);
        rx_f = cyc;
        repeat (2) @(posedge clock);
        #1;
        rx_ok = (txd == 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(posedge clock);
            #1;
            rx_b[i] = txd;
        end
        repeat (4) @(posedge clock);
        #1;
        rx_ok = rx_ok && (txd == 1'b1);
        rx_q.push_back(rx_b);
        fall_q.push_back(rx_f);
        ok_q.push_back(rx_ok);
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        dmem_addr = a;
        dmem_dout = d;
        dmem_we   = 1'b1;
        @(posedge clock);
        #1;
        dmem_we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        dmem_we   = 1'b0;
        dmem_addr = a;
        @(negedge clock);
        v = dmem_din;
    endtask

    task automatic wait_idle(input int bound);
        logic [15:0] v;
        int n;
        n = 0;
        rd(USTAT, v);
        while (v[0] && n < bound) begin
            @(posedge clock);
            rd(USTAT, v);
            n++;
        end
        if (v[0]) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles", v[0], bound);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        bit          we;
        logic [15:0] exp;
        string       nm;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] v;
    logic [15:0] ram_m [0:(2**RAM_AW)-1];
    bit          ram_v [0:(2**RAM_AW)-1];
    logic [7:0]  hello [0:5];
    logic [7:0]  tx_byte;
    logic        exp_bit;

    initial begin
        hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C;
        hello[3] = 8'h6C; hello[4] = 8'h6F; hello[5] = 8'h21;

        tbl.push_back('{16'h0005, 16'hBEEF, 1'b1, 16'h0000, "wr5"});
        tbl.push_back('{16'h0005, 16'h0000, 1'b0, 16'hBEEF, "raw_5"});
        tbl.push_back('{16'h8000, 16'h0000, 1'b0, UD,       "ud_8000"});
        tbl.push_back('{16'h0000, 16'h1111, 1'b1, 16'h0000, "wr0"});
        tbl.push_back('{16'h0100, 16'h2222, 1'b1, 16'h0000, "wr100"});
        tbl.push_back('{16'h0000, 16'h0000, 1'b0, 16'h1111, "no_alias_0"});
        tbl.push_back('{16'h0100, 16'h0000, 1'b0, UD,       "ud_0100"});
        tbl.push_back('{16'h00FF, 16'hA5A5, 1'b1, 16'h0000, "wrff"});
        tbl.push_back('{16'h00FF, 16'h0000, 1'b0, 16'hA5A5, "ram_top"});
        tbl.push_back('{UDATA,    16'h0000, 1'b0, 16'h0000, "uart_data_rd"});
        tbl.push_back('{USTAT,    16'hFFFF, 1'b1, 16'h0000, "wrstat"});
        tbl.push_back('{USTAT,    16'h0000, 1'b0, 16'h0004, "stat_idle"});
        tbl.push_back('{16'hFEFF, 16'h0000, 1'b0, UD,       "ud_feff"});
        tbl.push_back('{16'hFF02, 16'h0000, 1'b0, UD,       "ud_ff02"});
        tbl.push_back('{16'h0005, 16'h0001, 1'b1, 16'h0000, "wr5b"});
        tbl.push_back('{16'h0005, 16'h0000, 1'b0, 16'h0001, "overwrite_5"});

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_txd", {15'd0, txd}, 16'h0001);
        rd(USTAT, v);
        check("rst_stat", v, 16'h0004);
        n_rst = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_txd", {15'd0, txd}, 16'h0001);

        // Vector table
        foreach (tbl[i]) begin
            if (tbl[i].we) begin
                wr(tbl[i].addr, tbl[i].data);
            end else begin
                rd(tbl[i].addr, v);
                check(tbl[i].nm, v, tbl[i].exp);
                @(posedge clock);
                #1;
            end
        end

        // Single frame, 0x1248 -> byte 0x48
        tx_byte = 8'h48;
        wr(UDATA, 16'h1248);
        check("pre_fall_txd", {15'd0, txd}, 16'h0001);
        rd(USTAT, v);
        check("stat_cnt1", v, 16'h0010);
        @(posedge clock);
        #1;
        check("txd_fall", {15'd0, txd}, 16'h0000);
        rd(USTAT, v);
        check("stat_busy", v, 16'h0005);
        for (int k = 0; k < 10; k++) begin
            repeat (2) @(posedge clock);
            #1;
            if (k == 0) exp_bit = 1'b0;
            else if (k == 9) exp_bit = 1'b1;
            else exp_bit = (((tx_byte >> (k - 1)) & 8'h01) != 8'h00);
            check($sformatf("frame_bit%0d", k), {15'd0, txd}, {15'd0, exp_bit});
            if (k < 9) repeat (2) @(posedge clock);
        end
        @(posedge clock);
        rd(USTAT, v);
        check("busy_at_39", v, 16'h0005);
        @(posedge clock);
        rd(USTAT, v);
        check("idle_at_40", v, 16'h0004);

        // Hello: six back-to-back writes into a depth-4 FIFO
        wait_idle(100);
        repeat (3) @(posedge clock);
        #1;
        rx_q.delete();
        fall_q.delete();
        ok_q.delete();
        for (int i = 0; i < 6; i++) wr(UDATA, {8'hA5, hello[i]});
        rd(USTAT, v);
        check("stat_full", v, 16'h0043 | OVF_BIT);
        begin
            int n;
            n = 0;
            while (rx_q.size() < 5 && n < 400) begin
                @(posedge clock);
                n++;
            end
        end
        check("rx_count", 16'(rx_q.size()), 16'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            check($sformatf("rx_char%0d", i), {8'h00, rx_q[i]}, {8'h00, hello[i]});
            check($sformatf("rx_frame%0d", i), {15'd0, ok_q[i]}, 16'h0001);
            if (i > 0) check($sformatf("rx_gap%0d", i), 16'(fall_q[i] - fall_q[i-1]), 16'd40);
        end
        repeat (60) @(posedge clock);
        check("rx_no_6th", 16'(rx_q.size()), 16'd5);
        rd(USTAT, v);
        check("stat_ovf_sticky", v, 16'h0004 | OVF_BIT);
        @(posedge clock);
        #1;
        wr(USTAT, 16'h0000);
        rd(USTAT, v);
        check("stat_ovf_clr", v, 16'h0004);

        // Two bytes queued behind an active frame
        @(posedge clock);
        #1;
        wr(UDATA, 16'h0041);
        wr(UDATA, 16'h0042);
        wr(UDATA, 16'h0043);
        rd(USTAT, v);
        check("stat_q2", v, 16'h0021);
        wait_idle(300);

        // Reset in the middle of a data bit
        @(posedge clock);
        #1;
        wr(UDATA, 16'h0000);
        repeat (6) @(posedge clock);
        #1;
        check("mid_data_txd", {15'd0, txd}, 16'h0000);
        n_rst = 1'b0;
        #1;
        check("async_rst_txd", {15'd0, txd}, 16'h0001);
        rd(USTAT, v);
        n_rst = 1'b1;
        @(posedge clock);
        rd(USTAT, v);
        check("stat_after_rst", v, 16'h0004);
        check("txd_after_rst", {15'd0, txd}, 16'h0001);

        // Random RAM traffic against an array model
        for (int i = 0; i < 2**RAM_AW; i++) ram_v[i] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            int a;
            int op;
            logic [15:0] d;
            a  = $urandom_range(0, 2**RAM_AW - 1);
            op = $urandom_range(0, 9);
            if (op == 0) begin
                logic [15:0] far;
                far = 16'h0100 + 16'($urandom_range(0, 16'hFDFF));
                rd(far, v);
                check("rand_ud", v, UD);
                @(posedge clock);
                #1;
            end else if (op < 5 || !ram_v[a]) begin
                d = 16'($urandom());
                wr(16'(a), d);
                ram_m[a] = d;
                ram_v[a] = 1'b1;
            end else begin
                rd(16'(a), v);
                check("rand_ram", v, ram_m[a]);
                @(posedge clock);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
